audio_dac_serializer: RTL and testbench
=======================================

Name: audio_dac_serializer

Overview:
- Consumer end of the signed 32-bit mixed-sample stream produced by the note generator.
- Buffers samples in a small FIFO and serializes them as a left-justified, mono-duplicated stereo bitstream to the board's audio DAC codec.
- The block is the bit-clock and frame master, so BCLK, LRCK and DACDAT are all outputs.
- It also reports FIFO level and underruns back to the sequencer control logic.

Parameters:
- BCLK_DIV, 8, Clock cycles per BCLK half-period; must be ≥ 2 (BCLK = Clock/(2*BCLK_DIV)).
- OUT_W, 24, number of sample MSBs transmitted per channel slot; 1 ≤ OUT_W ≤ 32.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, ≥ 2.

Ports:
- Clock, input, 1, system clock; every register in the block uses its rising edge.
- nStart, input, 1, synchronous active-low reset.
- Sample_In, input, 32, signed two's-complement sample.
- Sample_Valid, input, 1, Sample_In is valid this cycle.
- Sample_Ready, output, 1, FIFO can accept a sample this cycle.
- BCLK, output, 1, codec bit clock.
- LRCK, output, 1, channel select; 1 = left slot, 0 = right slot.
- DACDAT, output, 1, serial data, MSB first.
- Fifo_Level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- Underrun, output, 1, sticky underrun flag; cleared only by reset.

Behaviour:
- Reset (nStart=0 sampled at a Clock edge):
  - BCLK=0, LRCK=0, DACDAT=0, Sample_Ready=0, Fifo_Level=0, Underrun=0.
  - Divider, bit counter, shift register and FIFO pointers all cleared.
  - Reset asserted mid-frame aborts the frame immediately; no partial data is retained.
- FIFO / handshake:
  - Sample_Ready = nStart_registered && (Fifo_Level != FIFO_DEPTH), registered. It is 0 in the first cycle after reset release and 1 from the next cycle.
  - A push occurs on a cycle with Sample_Valid && Sample_Ready. Sample_Valid with Ready=0 is ignored and the sample is dropped; the upstream source is free-running.
  - Pop and push in the same cycle: Fifo_Level is unchanged and both take effect.
  - A pop sees only entries present before the current cycle. A push into an empty FIFO in the same cycle as a frame-start pop counts as an underrun.
- Bit clock:
  - A divider counts 0..BCLK_DIV-1. At terminal count BCLK toggles and the divider wraps.
  - "Fall event" = the cycle in which BCLK goes 1→0.
- Frame:
  - 64 BCLK periods: 32 left-slot bits followed by 32 right-slot bits.
  - Bit counter 0..63 advances on each fall event and wraps 63→0.
  - LRCK = 1 when bit counter < 32, else 0. LRCK changes on the same fall event as the bit counter.
  - DACDAT changes only on fall events, so it is stable across BCLK rising edges.
- Frame start (fall event with bit counter wrapping to 0):
  - FIFO non-empty: pop the head sample into the frame holding register.
  - FIFO empty: load 0 into the holding register and set Underrun.
  - The first frame after reset, with an empty FIFO, therefore sets Underrun.
- Slot data:
  - Each slot transmits holding[31:32-OUT_W] MSB first, then (32-OUT_W) zeros.
  - The right slot retransmits the same value as the left slot (mono).
  - Slot bit k (k=0..31) is driven on DACDAT during slot position k; bit 0 is the MSB.
- Latency:
  - A sample pushed into an empty FIFO at least one cycle before a frame start has its MSB on DACDAT at that frame start's fall event.

Optional Feature:
- Macro: AUDIO_DAC_UNDERRUN_HOLD_EN.
- Defined: on underrun the holding register keeps the previous frame's sample, so the previous sample repeats. Underrun is still set.
- Not defined: on underrun the holding register is loaded with 0, giving silence.
- After reset the holding register is 0 in both builds.

Test Plan:
- Reset/idle: hold nStart=0 for 5 cycles, then release, BCLK_DIV=8.
  - During reset all outputs are 0.
  - BCLK period is 16 Clocks.
  - LRCK period is 1024 Clocks.
  - The first frame sets Underrun=1 and DACDAT stays 0.
- Serialization: push 32'h7FFF_FF00, then 32'h8000_0100, OUT_W=24.
  - Frame 1: both slots show 0x7FFFFF MSB first followed by 8 zeros.
  - Frame 2: both slots show 0x800001 followed by 8 zeros.
  - Underrun does not re-trigger after the initial empty frame.
- Backpressure: hold Sample_Valid=1 continuously with incrementing data, FIFO_DEPTH=4.
  - Fifo_Level saturates at 4 and Sample_Ready=0 while full.
  - Exactly one sample is accepted per frame after filling, and accepted samples appear in order.
- Underrun: push one sample 0x1234_5600, then stop.
  - The next frame carries 0x123456 and the following frame is all zeros, with Underrun=1.
  - Rerun with AUDIO_DAC_UNDERRUN_HOLD_EN defined: 0x123456 repeats and Underrun=1.
- Simultaneous events:
  - Push on the exact frame-start cycle into an empty FIFO: that frame is an underrun and the sample plays in the next frame.
  - Push and pop in the same cycle with Level=2: Level stays 2.
- Mid-frame reset: assert nStart=0 for 1 cycle at bit counter 40.
  - Next cycle: all outputs 0 and Fifo_Level=0.
  - The frame restarts from bit counter 0 after release.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
// Buffers signed 32-bit mixed samples in a small FIFO and sends them to the
// audio DAC codec as a left-justified stereo bitstream. Each sample is sent
// on both channels. This block is the BCLK/LRCK master.
// Build option: AUDIO_DAC_UNDERRUN_HOLD_EN. When it is defined, an underrun
// repeats the previous frame's sample. When it is undefined (the default),
// an underrun sends silence.
module audio_dac_serializer #(
    parameter int BCLK_DIV   = 8,
    parameter int OUT_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clock,
    input  logic                          nStart,
    input  logic [31:0]                   Sample_In,
    input  logic                          Sample_Valid,
    output logic                          Sample_Ready,
    output logic                          BCLK,
    output logic                          LRCK,
    output logic                          DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
    output logic                          Underrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    // Keeps the top OUT_W bits of the sample and zero-fills the rest of the slot.
    localparam logic [31:0]      SLOT_MASK = ~(32'hFFFF_FFFF >> OUT_W);

    typedef enum logic {
        FRAME_IDLE,
        FRAME_RUN
    } frame_state_t;

    frame_state_t      state;
    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic [31:0]       shift_reg;
    logic [31:0]       holding;
    logic [31:0]       next_hold;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              nstart_q;
    logic              tick;
    logic              fall_evt;
    logic              frame_start;
    logic              push;
    logic              pop;

    assign tick        = (div_cnt == DIV_LAST);
    assign fall_evt    = tick && BCLK;
    // The first fall event after reset starts a frame, so a frame aborted
    // by reset restarts cleanly from slot position 0.
    assign frame_start = fall_evt && ((state == FRAME_IDLE) || (bit_cnt == 6'd63));
    assign push        = Sample_Valid && Sample_Ready;
    // Pop only uses the registered level. A sample pushed in the same cycle
    // as a frame start therefore cannot rescue that frame.
    assign pop         = frame_start && (Fifo_Level != '0);

`ifdef AUDIO_DAC_UNDERRUN_HOLD_EN
    assign next_hold = pop ? fifo_mem[rd_ptr] : holding;
`else
    assign next_hold = pop ? fifo_mem[rd_ptr] : 32'd0;
`endif

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        level_next = Fifo_Level;
        if (push && !pop) begin
            level_next = Fifo_Level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = Fifo_Level - LVL_W'(1);
        end
    end

    // BCLK divider: toggle BCLK every BCLK_DIV clocks.
    always_ff @(posedge Clock) begin
        if (!nStart) begin
            div_cnt <= '0;
            BCLK    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            BCLK    <= ~BCLK;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Sample FIFO pointers, occupancy, and the registered ready handshake.
    always_ff @(posedge Clock) begin
        if (!nStart) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Fifo_Level   <= '0;
            nstart_q     <= 1'b0;
            Sample_Ready <= 1'b0;
        end else begin
            nstart_q     <= 1'b1;
            Sample_Ready <= nstart_q && (level_next != LVL_FULL);
            Fifo_Level   <= level_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage. Stale contents are harmless because reset clears the pointers.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Sample_In;
        end
    end

    // Frame sequencer. LRCK, DACDAT and the bit position all advance on BCLK falling edges.
    always_ff @(posedge Clock) begin
        if (!nStart) begin
            state     <= FRAME_IDLE;
            bit_cnt   <= 6'd0;
            LRCK      <= 1'b0;
            DACDAT    <= 1'b0;
            shift_reg <= 32'd0;
            holding   <= 32'd0;
            Underrun  <= 1'b0;
        end else if (fall_evt) begin
            if (frame_start) begin
                state     <= FRAME_RUN;
                bit_cnt   <= 6'd0;
                LRCK      <= 1'b1;
                holding   <= next_hold;
                DACDAT    <= next_hold[31];
                shift_reg <= (next_hold & SLOT_MASK) << 1;
                if (!pop) begin
                    Underrun <= 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
                LRCK    <= (bit_cnt < 6'd31);
                if (bit_cnt == 6'd31) begin
                    DACDAT    <= holding[31];
                    shift_reg <= (holding & SLOT_MASK) << 1;
                end else begin
                    DACDAT    <= shift_reg[31];
                    shift_reg <= shift_reg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer
// This bench drives audio_dac_serializer with directed and random sample
// streams. A reference model predicts each frame's sample and the
// per-cycle status outputs. A separate monitor reassembles each serial frame
// and compares it with the queued prediction.
// Build option: AUDIO_DAC_UNDERRUN_HOLD_EN selects the repeat-on-underrun model.
module tb_audio_dac_serializer;

    localparam int DIV     = 8;
    localparam int OUT_W   = 24;
    localparam int DEPTH   = 4;
    localparam int BIT_T   = 2 * DIV;
    localparam int FALL0   = 2 * DIV;
    localparam int FRAME_T = 64 * BIT_T;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic              Clock = 1'b0;
    logic              nStart = 1'b0;
    logic [31:0]       Sample_In = 32'd0;
    logic              Sample_Valid = 1'b0;
    logic              Sample_Ready;
    logic              BCLK;
    logic              LRCK;
    logic              DACDAT;
    logic [LVL_W-1:0]  Fifo_Level;
    logic              Underrun;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_edges = 0;
    logic [31:0] m_fifo[$];
    logic [31:0] exp_frames[$];
    logic        m_ready = 1'b0;
    logic        m_nstart_q = 1'b0;
    logic        m_underrun = 1'b0;
    logic [31:0] m_hold = 32'd0;

    // Monitor state.
    int          mon_cnt = 0;
    logic        mon_active = 1'b0;
    logic        mon_prev_bclk = 1'b0;
    logic        mon_prev_lr = 1'b0;
    logic [63:0] mon_bits = 64'd0;
    logic [63:0] mon_lr = 64'd0;

    audio_dac_serializer #(
        .BCLK_DIV   (DIV),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock        (Clock),
        .nStart       (nStart),
        .Sample_In    (Sample_In),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .BCLK         (BCLK),
        .LRCK         (LRCK),
        .DACDAT       (DACDAT),
        .Fifo_Level   (Fifo_Level),
        .Underrun     (Underrun)
    );

    always #5 Clock = ~Clock;

    // Compare one DUT value with its expected value and count the result.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Record a wait that ran past its budget as a failed comparison.
    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s at %0t: timed out waiting", name, $time);
    endtask

    function automatic bit is_frame_start(input int e);
        return (e >= FALL0) && (((e - FALL0) % FRAME_T) == 0);
    endfunction

    // Build the 64-bit frame: both slots carry the top OUT_W sample bits, then zero fill.
    function automatic logic [63:0] frame_bits(input logic [31:0] s);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            int k;
            k = i % 32;
            b[63-i] = (k < OUT_W) ? s[31-k] : 1'b0;
        end
        return b;
    endfunction

    // Reference model: sample order, FIFO occupancy and frame timing, advanced at each clock edge.
    always @(posedge Clock) begin
        if (!nStart) begin
            m_fifo.delete();
            exp_frames.delete();
            m_edges    = 0;
            m_ready    = 1'b0;
            m_nstart_q = 1'b0;
            m_underrun = 1'b0;
            m_hold     = 32'd0;
        end else begin
            bit accept;
            accept  = Sample_Valid && m_ready;
            m_edges = m_edges + 1;
            if (is_frame_start(m_edges)) begin
                if (m_fifo.size() > 0) begin
                    m_hold = m_fifo.pop_front();
                end else begin
                    m_underrun = 1'b1;
`ifndef AUDIO_DAC_UNDERRUN_HOLD_EN
                    m_hold = 32'd0;
`endif
                end
                exp_frames.push_back(m_hold);
            end
            if (accept) begin
                m_fifo.push_back(Sample_In);
            end
            m_ready    = m_nstart_q && (m_fifo.size() != DEPTH);
            m_nstart_q = 1'b1;
        end
    end

    // Per-cycle status check against the model, sampled mid-cycle.
    always @(negedge Clock) begin
        logic exp_lr;
        if (m_edges >= FALL0) begin
            exp_lr = (((m_edges - FALL0) % FRAME_T) / BIT_T) < 32;
        end else begin
            exp_lr = 1'b0;
        end
        check_output("bclk", 64'(BCLK), 64'((m_edges / DIV) % 2));
        check_output("lrck", 64'(LRCK), 64'(exp_lr));
        check_output("ready", 64'(Sample_Ready), 64'(m_ready));
        check_output("level", 64'(Fifo_Level), 64'(m_fifo.size()));
        check_output("underrun", 64'(Underrun), 64'(m_underrun));
        if (m_edges < FALL0) begin
            check_output("dacdat_idle", 64'(DACDAT), 64'd0);
        end
    end

    // Frame monitor: collect DACDAT/LRCK on each BCLK rise and compare each full frame.
    always @(negedge Clock) begin
        if (!nStart) begin
            mon_cnt       = 0;
            mon_active    = 1'b0;
            mon_prev_bclk = 1'b0;
            mon_prev_lr   = 1'b0;
        end else begin
            if (BCLK && !mon_prev_bclk) begin
                if (LRCK && !mon_prev_lr) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
                if (mon_active) begin
                    mon_bits[63-mon_cnt] = DACDAT;
                    mon_lr[63-mon_cnt]   = LRCK;
                    mon_cnt++;
                    if (mon_cnt == 64) begin
                        if (exp_frames.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL frame_unexpected at %0t: got %0h with no frame expected", $time, mon_bits);
                        end else begin
                            logic [31:0] s;
                            s = exp_frames.pop_front();
                            check_output("frame_data", mon_bits, frame_bits(s));
                            check_output("frame_lrck", mon_lr, {32'hFFFF_FFFF, 32'h0});
                        end
                        mon_active = 1'b0;
                    end
                end
                mon_prev_lr = LRCK;
            end
            mon_prev_bclk = BCLK;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Present one sample and hold it until the FIFO accepts it.
    task automatic apply_stimulus(input logic [31:0] data);
        int guard;
        guard        = 0;
        Sample_In    = data;
        Sample_Valid = 1'b1;
        while (!Sample_Ready && guard < 3 * FRAME_T) begin
            step(1);
            guard++;
        end
        if (guard >= 3 * FRAME_T) begin
            report_timeout("push_wait");
        end
        step(1);
        Sample_Valid = 1'b0;
    endtask

    // Advance so that the next clock edge is a frame start.
    task automatic step_to_before_frame_start();
        int guard;
        guard = 0;
        while (!is_frame_start(m_edges + 1) && guard < 2 * FRAME_T) begin
            step(1);
            guard++;
        end
        if (guard >= 2 * FRAME_T) begin
            report_timeout("frame_start_wait");
        end
    endtask

    initial begin
        logic [31:0] bp_data;
        int guard;

        // Reset: hold nStart low, then let the first frame underrun.
        nStart = 1'b0;
        step(5);
        check_output("rst_level", 64'(Fifo_Level), 64'd0);
        check_output("rst_dacdat", 64'(DACDAT), 64'd0);
        nStart = 1'b1;
        step(FALL0 + FRAME_T + 100);
        check_output("first_frame_underrun", 64'(Underrun), 64'd1);

        // Serialization of two known samples.
        apply_stimulus(32'h7FFF_FF00);
        apply_stimulus(32'h8000_0100);
        step(3 * FRAME_T);

        // Backpressure: Sample_Valid held high with incrementing data.
        bp_data = 32'h0001_0000;
        repeat (6 * FRAME_T) begin
            Sample_Valid = 1'b1;
            Sample_In    = bp_data;
            step(1);
            bp_data = bp_data + 32'h0000_0100;
        end
        check_output("bp_level_full", 64'(Fifo_Level), 64'(DEPTH));
        check_output("bp_ready_low", 64'(Sample_Ready), 64'd0);
        Sample_Valid = 1'b0;
        step(5 * FRAME_T);

        // A single sample followed by underrun.
        apply_stimulus(32'h1234_5600);
        step(3 * FRAME_T);

        // A push on the exact frame-start edge into an empty FIFO.
        step_to_before_frame_start();
        Sample_In    = $urandom;
        Sample_Valid = 1'b1;
        step(1);
        Sample_Valid = 1'b0;
        step(100);
        apply_stimulus($urandom);
        check_output("level_two", 64'(Fifo_Level), 64'd2);
        // A push and a pop in the same cycle with Level=2.
        step_to_before_frame_start();
        Sample_In    = $urandom;
        Sample_Valid = 1'b1;
        step(1);
        Sample_Valid = 1'b0;
        check_output("pushpop_level", 64'(Fifo_Level), 64'd2);
        step(3 * FRAME_T);

        // Random sparse traffic.
        repeat (3 * FRAME_T) begin
            Sample_Valid = ($urandom_range(0, 63) == 0);
            Sample_In    = $urandom;
            step(1);
        end
        Sample_Valid = 1'b0;

        // Reset in the middle of a frame, at bit position 40.
        apply_stimulus($urandom);
        apply_stimulus($urandom);
        guard = 0;
        while (!(m_edges >= FALL0 && (((m_edges - FALL0) % FRAME_T) / BIT_T) == 40)
               && guard < 2 * FRAME_T) begin
            step(1);
            guard++;
        end
        if (guard >= 2 * FRAME_T) begin
            report_timeout("bit40_wait");
        end
        nStart = 1'b0;
        step(1);
        check_output("midrst_level", 64'(Fifo_Level), 64'd0);
        check_output("midrst_bclk", 64'(BCLK), 64'd0);
        check_output("midrst_lrck", 64'(LRCK), 64'd0);
        check_output("midrst_dacdat", 64'(DACDAT), 64'd0);
        check_output("midrst_ready", 64'(Sample_Ready), 64'd0);
        check_output("midrst_underrun", 64'(Underrun), 64'd0);
        nStart = 1'b1;
        apply_stimulus(32'hCAFE_BA00);
        step(3 * FRAME_T);

        check_output("frames_pending", 64'(exp_frames.size() <= 1), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
